// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multicycle ALU; logic/arith/shift/branch ops finish in one cycle.
// Define ULA_MULDIV_EN to add the 32-step shift-add multiplier and restoring divider (codes 4/5).
module ula_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  sinal_controle,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  shamt,
  output logic [31:0] resultado,
  output logic        zero,
  output logic        desvio,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
`ifdef ULA_MULDIV_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif
  state_t      state_q, state_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d, desvio_q, desvio_d, busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [31:0] diff, sc_res;
  logic        sc_br, sc_dz;
  assign diff = A - B;
  always_comb begin
    sc_res = 32'd0;
    sc_dz  = 1'b0;
    case (sinal_controle)
      4'd0: sc_res = A & B;
      4'd1: sc_res = A | B;
      4'd2: sc_res = A + B;
      4'd3, 4'd9, 4'd10, 4'd11, 4'd12: sc_res = diff;
      4'd6: sc_res = A >> shamt;
      4'd7: sc_res = A << shamt;
      4'd8: sc_res = ~(A | B);
`ifdef ULA_MULDIV_EN
      4'd5: begin
        sc_res = 32'hFFFF_FFFF;
        sc_dz  = 1'b1;
      end
`endif
      default: sc_res = 32'd0;
    endcase
    sc_br = sinal_controle == 4'd9  ? A == B :
            sinal_controle == 4'd10 ? $signed(A) < $signed(B) :
            sinal_controle == 4'd11 ? $signed(A) > $signed(B) :
            sinal_controle == 4'd12 ? A != B : 1'b0;
  end
`ifdef ULA_MULDIV_EN
  // Shared iteration registers: mul uses a=multiplicand, b=multiplier, acc=sum;
  // div uses a=dividend shifting into quotient, b=divisor, acc=remainder.
  logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d, mul_acc;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d, go_calc;
  logic [32:0] rem_sh, rem_sub;
  assign go_calc = sinal_controle == 4'd4 || (sinal_controle == 4'd5 && B != 32'd0);
  assign rem_sh  = {acc_q, a_q[31]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign mul_acc = acc_q + (b_q[0] ? a_q : 32'd0);
`endif
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    zero_d   = zero_q;
    desvio_d = desvio_q;
    dz_d     = dz_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef ULA_MULDIV_EN
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        busy_d = 1'b1;
`ifdef ULA_MULDIV_EN
        if (go_calc) begin
          state_d  = CALC;
          a_d      = A;
          b_d      = B;
          acc_d    = 32'd0;
          cnt_d    = 5'd0;
          is_div_d = sinal_controle[0];
        end else
`endif
        begin
          state_d  = DONE;
          done_d   = 1'b1;
          res_d    = sc_res;
          zero_d   = sc_res == 32'd0;
          desvio_d = sc_br;
          dz_d     = sc_dz;
        end
      end
`ifdef ULA_MULDIV_EN
      CALC: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 5'd1;
        a_d    = is_div_q ? {a_q[30:0], ~rem_sub[32]} : a_q << 1;
        b_d    = is_div_q ? b_q : b_q >> 1;
        acc_d  = is_div_q ? (rem_sub[32] ? rem_sh[31:0] : rem_sub[31:0]) : mul_acc;
        if (cnt_q == 5'd31) begin
          state_d  = DONE;
          done_d   = 1'b1;
          res_d    = is_div_q ? a_d : acc_d;
          zero_d   = res_d == 32'd0;
          desvio_d = 1'b0;
          dz_d     = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      res_q    <= 32'd0;
      zero_q   <= 1'b1;
      desvio_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
`ifdef ULA_MULDIV_EN
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      desvio_q <= desvio_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
`ifdef ULA_MULDIV_EN
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
`endif
    end
  end
  assign resultado = res_q;
  assign zero      = zero_q;
  assign desvio    = desvio_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: randomized scoreboard bench for ula_multiciclo against a behavioural ALU model.
module tb_ula_multiciclo;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0]  sinal_controle = 4'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] resultado;
  logic        zero, desvio, busy, done, div_zero;
  typedef struct {logic [31:0] res; logic br; logic dz; int lat; int due;} exp_t;
  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [34:0] prev = '0;

  ula_multiciclo dut (
    .clock(clock), .reset(reset), .start(start), .sinal_controle(sinal_controle),
    .A(A), .B(B), .shamt(shamt), .resultado(resultado), .zero(zero),
    .desvio(desvio), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t e;
    e.res = 32'd0; e.br = 1'b0; e.dz = 1'b0; e.lat = 1; e.due = 0;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: e.res = a + b;
      4'd3: e.res = a - b;
`ifdef ULA_MULDIV_EN
      4'd4: begin e.res = a * b; e.lat = 33; end
      4'd5: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.dz = 1'b1; end
            else begin e.res = a / b; e.lat = 33; end
`endif
      4'd6: e.res = a >> sh;
      4'd7: e.res = a << sh;
      4'd8: e.res = ~(a | b);
      4'd9:  begin e.res = a - b; e.br = a == b; end
      4'd10: begin e.res = a - b; e.br = $signed(a) < $signed(b); end
      4'd11: begin e.res = a - b; e.br = $signed(a) > $signed(b); end
      4'd12: begin e.res = a - b; e.br = a != b; end
      default: e.res = 32'd0;
    endcase
    return e;
  endfunction

  task automatic wait_idle();
    int w = 0;
    while (busy !== 1'b0 && w < 100) begin
      @(posedge clock); #1;
      w++;
    end
    if (w >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL idle_wait busy still=%b after %0d cycles required=0", busy, w);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input bit track);
    exp_t e;
    wait_idle();
    sinal_controle = op; A = a; B = b; shamt = sh; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    e = model(op, a, b, sh);
    e.due = cyc - 1 + e.lat;
    if (track) sb.push_back(e);
    sinal_controle = 4'($urandom); A = $urandom; B = $urandom; shamt = 5'($urandom);
  endtask

  always @(negedge clock) begin
    if (reset) prev = {resultado, zero, desvio, div_zero};
    else begin
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done got done=1 with no operation pending, required done=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resultado", resultado, e.res);
          chk("zero", 32'(zero), 32'(e.res == 32'd0));
          chk("desvio", 32'(desvio), 32'(e.br));
          chk("div_zero", 32'(div_zero), 32'(e.dz));
          chk("done_cycle", cyc, e.due);
          chk("busy_at_done", 32'(busy), 32'd1);
        end
      end else begin
        n_chk++;
        if ({resultado, zero, desvio, div_zero} !== prev) begin
          n_fail++;
          $display("FAIL held_outputs got=%h required=%h", {resultado, zero, desvio, div_zero}, prev);
        end
      end
      prev = {resultado, zero, desvio, div_zero};
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_resultado", resultado, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_desvio", 32'(desvio), 32'd0);
    reset = 1'b0;
    issue(4'd2, 32'd7, 32'd5, 5'd0, 1);
    issue(4'd3, 32'd0, 32'd1, 5'd0, 1);
    issue(4'd10, 32'hFFFF_FFFE, 32'd1, 5'd0, 1);
    issue(4'd11, 32'hFFFF_FFFE, 32'd1, 5'd0, 1);
    issue(4'd13, 32'd9, 32'd3, 5'd0, 1);
    issue(4'd14, 32'd9, 32'd3, 5'd0, 1);
    issue(4'd15, 32'd9, 32'd3, 5'd0, 1);
    issue(4'd4, 32'd1000, 32'd3000, 5'd0, 1);
`ifdef ULA_MULDIV_EN
    repeat (5) begin @(posedge clock); #1; end
    start = 1'b1; sinal_controle = 4'd2;
    repeat (2) begin @(posedge clock); #1; end
    start = 1'b0;
`endif
    issue(4'd5, 32'd100, 32'd7, 5'd0, 1);
    issue(4'd5, 32'd42, 32'd0, 5'd0, 1);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 5'd0, 1);
    issue(4'd9, 32'd5, 32'd5, 5'd0, 1);
    issue(4'd12, 32'd5, 32'd5, 5'd0, 1);
    issue(4'd6, 32'h8000_0000, 32'd0, 5'd31, 1);
    issue(4'd7, 32'h0000_0003, 32'd0, 5'd30, 1);
    issue(4'd8, 32'h0F0F_0000, 32'h0000_F0F0, 5'd0, 1);
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = ra;
        2: rb = $urandom_range(1, 300);
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb, 5'($urandom), 1);
    end
`ifdef ULA_MULDIV_EN
    issue(4'd5, 32'd100, 32'd7, 5'd0, 0);
    repeat (10) begin @(posedge clock); #1; end
    chk("abort_busy_before", 32'(busy), 32'd1);
`else
    wait_idle();
`endif
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_resultado", resultado, 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    reset = 1'b0;
    repeat (40) begin @(posedge clock); #1; end
    issue(4'd2, 32'd7, 32'd5, 5'd0, 1);
    wait_idle();
    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named clock and reset.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  operation request, sampled only in IDLE.
REQ-005 sinal_controle  input  4  operation code from the ALU control decoder; captured at the accepted start.
REQ-006 A  input  32  operand A (rs); captured at the accepted start.
REQ-007 B  input  32  operand B (rt/immediate); captured at the accepted start.
REQ-008 shamt  input  5  shift amount; captured at the accepted start.
REQ-009 resultado  output  32  registered result; held until the next done.
REQ-010 zero  output  1  registered, equals (resultado == 0).
REQ-011 desvio  output  1  registered branch-taken flag.
REQ-012 busy  output  1  high in CALC and DONE.
REQ-013 done  output  1  single-cycle pulse; result valid.
REQ-014 div_zero  output  1  registered, set by a divide with B == 0.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE; start accepted only in IDLE; start in CALC/DONE ignored.
REQ-016 Single-cycle codes: 0 and, 1 or, 2 add, 3 sub, 6 A>>shamt logical, 7 A<<shamt, 8 nor; IDLE+start -> DONE; done=1 in the following cycle with resultado updated.
REQ-017 Branch codes (desvio result, resultado = A-B): 9 beq A==B; 10 blt signed A<B; 11 bgt signed A>B; 12 bnq A!=B; single-cycle path.
REQ-018 desvio SHALL be 0 for every non-branch code.
REQ-019 Codes 13, 14 and 15 SHALL complete on the single-cycle path with resultado=0, desvio=0.
REQ-020 Code 4 mul SHALL be unsigned shift-add, one bit per cycle, 32 CALC cycles; resultado = low 32 bits of A*B.
REQ-021 Code 5 div SHALL be unsigned restoring division, 32 CALC cycles; resultado = quotient floor(A/B).
REQ-022 Mul/div latency: start accepted in cycle N, done=1 in cycle N+33.
REQ-023 Divide by B==0 SHALL skip CALC, take the single-cycle path, set resultado=32'hFFFFFFFF and div_zero=1.
REQ-024 div_zero SHALL be cleared on every other completed operation.
REQ-025 add/sub SHALL wrap modulo 2^32 with no overflow indication.
REQ-026 DONE SHALL last one cycle and return to IDLE; start is accepted again in the cycle after DONE.
REQ-027 Changes to A, B, shamt and sinal_controle after acceptance SHALL NOT affect the operation in progress.
REQ-028 resultado, zero, desvio and div_zero SHALL change only in the cycle that done is asserted.

Reset
REQ-029 Reset SHALL force IDLE and clear resultado, desvio, busy, done, div_zero and the iteration counter; zero reads 1.
REQ-030 Reset asserted in CALC SHALL abort the operation with no done pulse; the next start after release behaves normally.

Configuration
REQ-031 When ULA_MULDIV_EN is defined, codes 4 and 5 SHALL execute as specified in REQ-020..REQ-023.
REQ-032 When ULA_MULDIV_EN is undefined, the mul/div datapath and CALC state SHALL be absent; codes 4 and 5 SHALL take the single-cycle path with resultado=0 and div_zero=0.

Verification
REQ-033 Reset sequence: reset=1 -> resultado=0, zero=1, busy=0, done=0, div_zero=0.
REQ-034 add: code 2, A=7, B=5, start -> next cycle done=1, resultado=12; code 3, A=0, B=1 -> resultado=32'hFFFFFFFF.
REQ-035 blt: code 10, A=32'hFFFFFFFE, B=1 -> desvio=1; bgt with the same operands -> desvio=0.
REQ-036 mul: code 4, A=1000, B=3000 -> done exactly 33 cycles after start, resultado=3000000; a second start mid-CALC is ignored.
REQ-037 div: code 5, A=100, B=7 -> resultado=14 after 33 cycles; B=0 -> next cycle resultado=32'hFFFFFFFF, div_zero=1.
REQ-038 Abort: reset pulsed 10 cycles into a div -> no done; busy=0; a following add completes normally.
